// File: rtl/control_sequencer_if.sv
// Control/flag bundle between the microstep sequencer and the datapath.
// master = sequencer (drives controls, reads opcode and flags), slave = datapath.
interface control_sequencer_if;
    logic [3:0] opcode;
    logic       CF;
    logic       ZF;
    logic       pc_out;
    logic       pc_inc;
    logic       pc_load;
    logic       mar_load;
    logic       ram_out;
    logic       ram_load;
    logic       ir_load;
    logic       ir_out;
    logic       a_load;
    logic       a_out;
    logic       b_load;
    logic       alu_out;
    logic       sub;
    logic       out_load;
    logic       halt;
    logic [2:0] step;

    modport master (
        input  opcode, CF, ZF,
        output pc_out, pc_inc, pc_load, mar_load, ram_out, ram_load, ir_load, ir_out,
               a_load, a_out, b_load, alu_out, sub, out_load, halt, step
    );

    modport slave (
        output opcode, CF, ZF,
        input  pc_out, pc_inc, pc_load, mar_load, ram_out, ram_load, ir_load, ir_out,
               a_load, a_out, b_load, alu_out, sub, out_load, halt, step
    );
endinterface

// File: rtl/control_sequencer.sv
// Microstep sequencer for the 8-bit bus machine: fetch T0/T1, opcode-specific execute T2..T4.
// state | meaning
// T0    | fetch: PC -> MAR
// T1    | fetch: RAM -> IR, PC++
// T2    | execute step 1 (every opcode)
// T3    | execute step 2 (LDA/ADD/SUB/STA, or idle when EARLY_END=0)
// T4    | execute step 3 (ADD/SUB, or idle when EARLY_END=0)
module control_sequencer #(
    parameter bit EARLY_END = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    control_sequencer_if.master ctl
);
    typedef enum logic [2:0] {T0 = 3'd0, T1 = 3'd1, T2 = 3'd2, T3 = 3'd3, T4 = 3'd4} step_t;

    step_t step_q, step_d, last_step;
    logic  halted_q, halted_d;

    logic c_pc_out, c_pc_inc, c_pc_load, c_mar_load, c_ram_out, c_ram_load, c_ir_load;
    logic c_ir_out, c_a_load, c_a_out, c_b_load, c_alu_out, c_sub, c_out_load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_q   <= T0;
            halted_q <= 1'b0;
        end else begin
            step_q   <= step_d;
            halted_q <= halted_d;
        end
    end

    always_comb begin
        last_step = T2;
        case (ctl.opcode)
            4'd1, 4'd4: last_step = T3;
            4'd2, 4'd3: last_step = T4;
            default:    last_step = T2;
        endcase
    end

    always_comb begin
        c_pc_out   = 1'b0;
        c_pc_inc   = 1'b0;
        c_pc_load  = 1'b0;
        c_mar_load = 1'b0;
        c_ram_out  = 1'b0;
        c_ram_load = 1'b0;
        c_ir_load  = 1'b0;
        c_ir_out   = 1'b0;
        c_a_load   = 1'b0;
        c_a_out    = 1'b0;
        c_b_load   = 1'b0;
        c_alu_out  = 1'b0;
        c_sub      = 1'b0;
        c_out_load = 1'b0;
        step_d     = step_q;
        halted_d   = halted_q;

        if (!halted_q) begin
            case (step_q)
                T0: begin
                    c_pc_out   = 1'b1;
                    c_mar_load = 1'b1;
                end
                T1: begin
                    c_ram_out = 1'b1;
                    c_ir_load = 1'b1;
                    c_pc_inc  = 1'b1;
                end
                T2: begin
                    case (ctl.opcode)
                        4'd1, 4'd2, 4'd3, 4'd4: begin
                            c_ir_out   = 1'b1;
                            c_mar_load = 1'b1;
                        end
                        4'd5: begin
                            c_ir_out = 1'b1;
                            c_a_load = 1'b1;
                        end
                        4'd6: begin
                            c_ir_out  = 1'b1;
                            c_pc_load = 1'b1;
                        end
                        4'd7: begin
                            c_ir_out  = ctl.CF;
                            c_pc_load = ctl.CF;
                        end
                        4'd8: begin
                            c_ir_out  = ctl.ZF;
                            c_pc_load = ctl.ZF;
                        end
                        4'd14: begin
                            c_a_out    = 1'b1;
                            c_out_load = 1'b1;
                        end
                        4'd15: halted_d = 1'b1;
                        default: ;
                    endcase
                end
                T3: begin
                    case (ctl.opcode)
                        4'd1: begin
                            c_ram_out = 1'b1;
                            c_a_load  = 1'b1;
                        end
                        4'd2, 4'd3: begin
                            c_ram_out = 1'b1;
                            c_b_load  = 1'b1;
                            c_sub     = (ctl.opcode == 4'd3);
                        end
                        4'd4: begin
                            c_a_out    = 1'b1;
                            c_ram_load = 1'b1;
                        end
                        default: ;
                    endcase
                end
                T4: begin
                    if (ctl.opcode == 4'd2 || ctl.opcode == 4'd3) begin
                        c_alu_out = 1'b1;
                        c_a_load  = 1'b1;
                        c_sub     = (ctl.opcode == 4'd3);
                    end
                end
                default: ;
            endcase

            if (EARLY_END ? (step_q == last_step) : (step_q == T4))
                step_d = T0;
            else
                step_d = step_t'(3'(step_q + 3'd1));
        end
    end

    // Controls are gated by rst_n so they drop the instant reset asserts, not at the next edge.
    assign ctl.pc_out   = rst_n & c_pc_out;
    assign ctl.pc_inc   = rst_n & c_pc_inc;
    assign ctl.pc_load  = rst_n & c_pc_load;
    assign ctl.mar_load = rst_n & c_mar_load;
    assign ctl.ram_out  = rst_n & c_ram_out;
    assign ctl.ram_load = rst_n & c_ram_load;
    assign ctl.ir_load  = rst_n & c_ir_load;
    assign ctl.ir_out   = rst_n & c_ir_out;
    assign ctl.a_load   = rst_n & c_a_load;
    assign ctl.a_out    = rst_n & c_a_out;
    assign ctl.b_load   = rst_n & c_b_load;
    assign ctl.alu_out  = rst_n & c_alu_out;
    assign ctl.sub      = rst_n & c_sub;
    assign ctl.out_load = rst_n & c_out_load;
    assign ctl.halt     = rst_n & halted_q;
    assign ctl.step     = step_q;
endmodule

// File: tb/tb_control_sequencer.sv
// Randomized scoreboard bench for control_sequencer, two instances (EARLY_END=1 and EARLY_END=0).
module tb_control_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    control_sequencer_if ifc0();
    control_sequencer_if ifc1();

    control_sequencer #(.EARLY_END(1'b1)) dut0 (.clk(clk), .rst_n(rst_n), .ctl(ifc0));
    control_sequencer #(.EARLY_END(1'b0)) dut1 (.clk(clk), .rst_n(rst_n), .ctl(ifc1));

    // Control word bits (14..0), followed by the 3-bit step.
    localparam logic [14:0] PC_OUT = 15'h4000, PC_INC = 15'h2000, PC_LOAD = 15'h1000,
                            MAR_LD = 15'h0800, RAM_OUT = 15'h0400, RAM_LD = 15'h0200,
                            IR_LD = 15'h0100, IR_OUT = 15'h0080, A_LD = 15'h0040,
                            A_OUT = 15'h0020, B_LD = 15'h0010, ALU_OUT = 15'h0008,
                            SUB = 15'h0004, OUT_LD = 15'h0002, HALT = 15'h0001;

    logic [17:0] act0, act1;
    assign act0 = {ifc0.pc_out, ifc0.pc_inc, ifc0.pc_load, ifc0.mar_load, ifc0.ram_out,
                   ifc0.ram_load, ifc0.ir_load, ifc0.ir_out, ifc0.a_load, ifc0.a_out,
                   ifc0.b_load, ifc0.alu_out, ifc0.sub, ifc0.out_load, ifc0.halt, ifc0.step};
    assign act1 = {ifc1.pc_out, ifc1.pc_inc, ifc1.pc_load, ifc1.mar_load, ifc1.ram_out,
                   ifc1.ram_load, ifc1.ir_load, ifc1.ir_out, ifc1.a_load, ifc1.a_out,
                   ifc1.b_load, ifc1.alu_out, ifc1.sub, ifc1.out_load, ifc1.halt, ifc1.step};

    int compared = 0;
    int mismatched = 0;

    logic [17:0] exp_q0[$];
    logic [17:0] exp_q1[$];
    int dir_q0[$];
    int dir_q1[$];

    int       mstep[2];
    bit       mhalted[2];
    bit [3:0] op[2];
    bit       cf[2];
    bit       zf[2];

    // Microprogram as written in the machine's instruction table.
    function automatic logic [14:0] ctrl_of(int t, bit [3:0] o, bit c, bit z);
        if (t == 0) return PC_OUT | MAR_LD;
        if (t == 1) return RAM_OUT | IR_LD | PC_INC;
        case (o)
            4'd1:  return (t == 2) ? (IR_OUT | MAR_LD) : (t == 3) ? (RAM_OUT | A_LD) : 15'h0;
            4'd2:  return (t == 2) ? (IR_OUT | MAR_LD) : (t == 3) ? (RAM_OUT | B_LD) : (ALU_OUT | A_LD);
            4'd3:  return (t == 2) ? (IR_OUT | MAR_LD) : (t == 3) ? (RAM_OUT | B_LD | SUB)
                                                                  : (ALU_OUT | A_LD | SUB);
            4'd4:  return (t == 2) ? (IR_OUT | MAR_LD) : (t == 3) ? (A_OUT | RAM_LD) : 15'h0;
            4'd5:  return (t == 2) ? (IR_OUT | A_LD) : 15'h0;
            4'd6:  return (t == 2) ? (IR_OUT | PC_LOAD) : 15'h0;
            4'd7:  return (t == 2 && c) ? (IR_OUT | PC_LOAD) : 15'h0;
            4'd8:  return (t == 2 && z) ? (IR_OUT | PC_LOAD) : 15'h0;
            4'd14: return (t == 2) ? (A_OUT | OUT_LD) : 15'h0;
            default: return 15'h0;
        endcase
    endfunction

    function automatic int last_of(bit [3:0] o);
        if (o == 4'd1 || o == 4'd4) return 3;
        if (o == 4'd2 || o == 4'd3) return 4;
        return 2;
    endfunction

    function automatic bit [3:0] next_op(int d);
        if (d == 0 && dir_q0.size() > 0) return 4'(dir_q0.pop_front());
        if (d == 1 && dir_q1.size() > 0) return 4'(dir_q1.pop_front());
        return 4'($urandom_range(0, 14));
    endfunction

    task automatic cycle(input bit rv);
        @(posedge clk);
        #1;
        rst_n = rv;
        for (int d = 0; d < 2; d++) begin
            logic [17:0] e;
            if (!rv) begin
                mstep[d]   = 0;
                mhalted[d] = 1'b0;
                e          = '0;
            end else begin
                if (mstep[d] == 0 && !mhalted[d]) op[d] = next_op(d);
                cf[d] = 1'($urandom_range(0, 1));
                zf[d] = 1'($urandom_range(0, 1));
                if (mhalted[d]) begin
                    e = {HALT, 3'(mstep[d])};
                end else begin
                    int last;
                    e = {ctrl_of(mstep[d], op[d], cf[d], zf[d]), 3'(mstep[d])};
                    if (op[d] == 4'd15 && mstep[d] == 2) mhalted[d] = 1'b1;
                    last = (d == 0) ? last_of(op[d]) : 4;
                    mstep[d] = (mstep[d] == last) ? 0 : mstep[d] + 1;
                end
            end
            if (d == 0) exp_q0.push_back(e);
            else        exp_q1.push_back(e);
        end
        ifc0.opcode = op[0];
        ifc0.CF     = cf[0];
        ifc0.ZF     = zf[0];
        ifc1.opcode = op[1];
        ifc1.CF     = cf[1];
        ifc1.ZF     = zf[1];
    endtask

    // Monitor: every cycle the DUTs present a control word; pop and compare.
    logic [17:0] mon_e;
    always @(negedge clk) begin
        if (exp_q0.size() > 0) begin
            mon_e = exp_q0.pop_front();
            compared++;
            if (act0 !== mon_e) begin
                mismatched++;
                $display("FAIL ctrl_ee1 t=%0t: actual %b required %b", $time, act0, mon_e);
            end
        end
        if (exp_q1.size() > 0) begin
            mon_e = exp_q1.pop_front();
            compared++;
            if (act1 !== mon_e) begin
                mismatched++;
                $display("FAIL ctrl_ee0 t=%0t: actual %b required %b", $time, act1, mon_e);
            end
        end
        compared++;
        if (32'(ifc0.pc_out) + 32'(ifc0.ram_out) + 32'(ifc0.ir_out) + 32'(ifc0.a_out)
            + 32'(ifc0.alu_out) > 1 ||
            32'(ifc1.pc_out) + 32'(ifc1.ram_out) + 32'(ifc1.ir_out) + 32'(ifc1.a_out)
            + 32'(ifc1.alu_out) > 1) begin
            mismatched++;
            $display("FAIL bus_onehot t=%0t: actual %b / %b required at most one driver",
                     $time, act0, act1);
        end
    end

    initial begin
        bit found;
        for (int d = 0; d < 2; d++) begin
            mstep[d] = 0; mhalted[d] = 1'b0; op[d] = 4'd0; cf[d] = 1'b0; zf[d] = 1'b0;
        end
        ifc0.opcode = 4'd0; ifc0.CF = 1'b0; ifc0.ZF = 1'b0;
        ifc1.opcode = 4'd0; ifc1.CF = 1'b0; ifc1.ZF = 1'b0;

        // Directed opening program, then random opcodes (no HLT).
        dir_q0 = '{1, 3, 5, 7, 7, 7, 8, 8, 8, 2, 4, 14, 6};
        dir_q1 = '{1, 3, 5, 7, 7, 7, 8, 8, 8, 2, 4, 14, 6};
        repeat (3) cycle(1'b0);
        repeat (1500) cycle(1'b1);

        // Reset in the middle of ADD, at T3 of the EARLY_END=1 instance.
        dir_q0.push_back(2);
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            cycle(1'b1);
            if (mstep[0] == 3 && op[0] == 4'd2 && !mhalted[0]) found = 1'b1;
        end
        compared++;
        if (!found) begin
            mismatched++;
            $display("FAIL add_t3_reach: actual not reached required ADD T3 within 100 cycles");
        end
        repeat (2) cycle(1'b0);
        repeat (300) cycle(1'b1);

        // HLT: both instances halt and hold.
        dir_q0.push_back(15);
        dir_q1.push_back(15);
        repeat (40) cycle(1'b1);
        compared++;
        if (!(mhalted[0] && mhalted[1])) begin
            mismatched++;
            $display("FAIL halt_reach: actual model not halted required halted after HLT");
        end
        repeat (2) cycle(1'b0);
        repeat (200) cycle(1'b1);

        @(negedge clk);
        #1;
        compared++;
        if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
            mismatched++;
            $display("FAIL drain: actual %0d/%0d pending required 0/0", exp_q0.size(), exp_q1.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
